// File: rtl/lightpipe_pkg.sv
// Shared definitions for the ADAT lightpipe link supervisor: the state
// encoding, the nominal frame periods and the output widths.
package lightpipe_pkg;

  // Nominal mclk cycles per frame at 50 MHz
  localparam int NOM_PERIOD_44K1 = 1134;
  localparam int NOM_PERIOD_48K  = 1042;

  localparam int CNT_W_DEF = 12;
  localparam int STATE_W   = 3;
  localparam int ERR_W     = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_ACQUIRE  = 3'd1,
    ST_LOCKED   = 3'd2,
    ST_HOLDOVER = 3'd3,
    ST_FAULT    = 3'd4
  } link_state_t;

endpackage

// File: rtl/lightpipe_link_ctrl_wc_period_meter.sv
// Word clock period meter: rising-edge detect, frame period counter,
// missing-edge timeout and good/bad classification of each measured period.
module wc_period_meter
  import lightpipe_pkg::*;
#(
  parameter int NOM_PERIOD = NOM_PERIOD_44K1,
  parameter int TOL        = 16,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             mclk,
  input  logic             rst,
  input  logic             clear,
  input  logic             rx_wordclock,
  output logic             wc_edge,
  output logic             good,
  output logic             bad,
  output logic             timeout,
  output logic [CNT_W-1:0] period
);

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(2 * NOM_PERIOD - 1);
  localparam logic [CNT_W-1:0] PERIOD_LO   = CNT_W'(NOM_PERIOD - TOL);
  localparam logic [CNT_W-1:0] PERIOD_HI   = CNT_W'(NOM_PERIOD + TOL);

  logic             wc_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;

  // The measured period of a frame is cnt+1, so the same saturating
  // increment serves both the counter and the period capture.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign wc_edge = rx_wordclock & ~wc_q;
  assign timeout = ~wc_edge & (cnt == TIMEOUT_CNT);
  assign good    = wc_edge & (cnt_inc >= PERIOD_LO) & (cnt_inc <= PERIOD_HI);
  assign bad     = wc_edge & ~good;

  // Edge history, period counter and captured period
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge mclk) begin
    if (rst) begin
      wc_q   <= 1'b0;
      cnt    <= '0;
      period <= '0;
    end else begin
      wc_q <= rx_wordclock;
      if (clear) begin
        cnt    <= '0;
        period <= '0;
      end else if (wc_edge) begin
        cnt    <= '0;
        period <= cnt_inc;
      end else if (timeout) begin
        cnt <= '0;
      end else begin
        cnt <= cnt_inc;
      end
    end
  end

endmodule

// File: rtl/lightpipe_link_ctrl.sv
// ADAT lightpipe link supervisor: sequences acquisition, lock, holdover and
// fault from the measured word clock period and the dpll lock flag, and
// drives mute / clock-source select plus a saturating fault counter.
module lightpipe_link_ctrl
  import lightpipe_pkg::*;
#(
  parameter int NOM_PERIOD  = NOM_PERIOD_44K1,
  parameter int TOL         = 16,
  parameter int LOCK_FRAMES = 8,
  parameter int LOSS_FRAMES = 2,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic               mclk,
  input  logic               rst,
  input  logic               enable,
  input  logic               rx_wordclock,
  input  logic               pll_locked,
  input  logic               err_clr,
  output logic               mute,
  output logic               link_locked,
  output logic               src_sel,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   period,
  output logic [ERR_W-1:0]   err_count
);

  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam int BAD_W  = $clog2(LOSS_FRAMES + 1);
  localparam logic [GOOD_W-1:0] LOCK_N = GOOD_W'(LOCK_FRAMES);
  localparam logic [BAD_W-1:0]  LOSS_N = BAD_W'(LOSS_FRAMES);

  link_state_t       cur_state, nxt_state;
  logic [GOOD_W-1:0] good_cnt, good_nxt;
  logic [BAD_W-1:0]  bad_cnt, bad_nxt;
  logic              primed, primed_nxt;
  logic              wc_edge, edge_good, edge_bad, timeout;
  logic              meter_clear, frame_good, frame_bad;

  // Idle holds the meter cleared so period reads 0 and measurement restarts
  // cleanly from the first cycle of acquisition.
  assign meter_clear = (cur_state == ST_IDLE) || (nxt_state == ST_IDLE);

  wc_period_meter #(
    .NOM_PERIOD (NOM_PERIOD),
    .TOL        (TOL),
    .CNT_W      (CNT_W)
  ) u_meter (
    .mclk         (mclk),
    .rst          (rst),
    .clear        (meter_clear),
    .rx_wordclock (rx_wordclock),
    .wc_edge      (wc_edge),
    .good         (edge_good),
    .bad          (edge_bad),
    .timeout      (timeout),
    .period       (period)
  );

  // The first edge after entering acquisition has no reference, so only
  // primed edges are judged; a timeout is a bad frame either way.
  assign frame_good = edge_good & primed;
  assign frame_bad  = (edge_bad & primed) | timeout;

  // Next-state and frame-counter logic
  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    nxt_state  = cur_state;
    good_nxt   = good_cnt;
    bad_nxt    = bad_cnt;
    primed_nxt = primed;
    case (cur_state)
      ST_IDLE: begin
        if (enable) nxt_state = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (wc_edge) primed_nxt = 1'b1;
        if (frame_bad) good_nxt = '0;
        else if (frame_good && good_cnt < LOCK_N) good_nxt = good_cnt + GOOD_W'(1);
        if (good_nxt == LOCK_N && pll_locked) nxt_state = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (!pll_locked) begin
          nxt_state = ST_FAULT;
        end else if (frame_bad) begin
          nxt_state = ST_HOLDOVER;
          bad_nxt   = BAD_W'(1);
        end
      end
      ST_HOLDOVER: begin
        if (!pll_locked) begin
          nxt_state = ST_FAULT;
        end else if (frame_good) begin
          nxt_state = ST_LOCKED;
          bad_nxt   = '0;
        end else if (frame_bad) begin
          bad_nxt = bad_cnt + BAD_W'(1);
          if (bad_nxt >= LOSS_N) nxt_state = ST_FAULT;
        end
      end
      ST_FAULT: nxt_state = ST_ACQUIRE;
      default:  nxt_state = ST_IDLE;
    endcase
    if (!enable) nxt_state = ST_IDLE;
    // Every fresh acquisition starts with empty counters and unprimed
    if (nxt_state == ST_ACQUIRE && cur_state != ST_ACQUIRE) begin
      good_nxt   = '0;
      bad_nxt    = '0;
      primed_nxt = 1'b0;
    end
  end

  // State, counters, registered outputs and the saturating fault count
  always_ff @(posedge mclk) begin
    if (rst) begin
      cur_state   <= ST_IDLE;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      primed      <= 1'b0;
      mute        <= 1'b1;
      link_locked <= 1'b0;
      src_sel     <= 1'b0;
      err_count   <= '0;
    end else begin
      cur_state   <= nxt_state;
      good_cnt    <= good_nxt;
      bad_cnt     <= bad_nxt;
      primed      <= primed_nxt;
      mute        <= (nxt_state != ST_LOCKED);
      link_locked <= (nxt_state == ST_LOCKED) || (nxt_state == ST_HOLDOVER);
      src_sel     <= (nxt_state == ST_LOCKED) || (nxt_state == ST_HOLDOVER);
      if (err_clr)
        err_count <= '0;
      else if (nxt_state == ST_FAULT && cur_state != ST_FAULT && err_count != '1)
        err_count <= err_count + ERR_W'(1);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_lightpipe_link_ctrl.sv
// Directed bench for lightpipe_link_ctrl: a table of frame periods with
// hand-computed outputs, then hand-written timeout, pll-drop, enable and
// reset sequences.
module tb_lightpipe_link_ctrl;

  logic        mclk = 1'b0;
  logic        rst, enable, rx_wordclock, pll_locked, err_clr;
  logic        mute, link_locked, src_sel;
  logic [2:0]  state;
  logic [11:0] period;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int len;   // cycles from the previous edge (or acquisition start)
    int st;
    int mute;
    int ll;
    int src;
    int per;   // -1: priming edge, period not compared
    int err;
  } vec_t;

  vec_t vecs[$];

  lightpipe_link_ctrl dut (
    .mclk         (mclk),
    .rst          (rst),
    .enable       (enable),
    .rx_wordclock (rx_wordclock),
    .pll_locked   (pll_locked),
    .err_clr      (err_clr),
    .mute         (mute),
    .link_locked  (link_locked),
    .src_sel      (src_sel),
    .state        (state),
    .period       (period),
    .err_count    (err_count)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  // One-cycle high pulse on the word clock; outputs reflect it on return
  task automatic edge_tick();
    rx_wordclock = 1'b1;
    tick();
    rx_wordclock = 1'b0;
  endtask

  task automatic check_outs(input string tag, input int st, input int m, input int ll,
                            input int s, input int err);
    check({tag, "_state"}, 32'(state), 32'(st));
    check({tag, "_mute"}, 32'(mute), 32'(m));
    check({tag, "_link_locked"}, 32'(link_locked), 32'(ll));
    check({tag, "_src_sel"}, 32'(src_sel), 32'(s));
    check({tag, "_err_count"}, 32'(err_count), 32'(err));
  endtask

  // From ACQUIRE: priming edge plus eight nominal frames; with hold the
  // pll is low throughout and lock must wait for it to rise.
  task automatic relock(input bit hold, input int err);
    if (hold) pll_locked = 1'b0;
    edge_tick();
    for (int k = 0; k < 8; k++) begin
      gap(1133);
      edge_tick();
    end
    if (hold) begin
      check("hold_waits_for_pll", 32'(state), 32'd1);
      pll_locked = 1'b1;
      tick();
    end
    check_outs("relock", 2, 0, 1, 1, err);
    check("relock_period", 32'(period), 32'd1134);
  endtask

  task automatic add(input int len, input int st, input int m, input int ll, input int s,
                     input int per, input int err);
    vecs.push_back('{len, st, m, ll, s, per, err});
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; rx_wordclock = 1'b0; pll_locked = 1'b1; err_clr = 1'b0;

    // Frame sequence from acquisition start. 1151 and 1117 are each placed so
    // that misjudging them as good would give an early lock.
    add(5,    1, 1, 0, 0, -1,   0);  // priming edge
    add(1134, 1, 1, 0, 0, 1134, 0);  // good 1
    add(1151, 1, 1, 0, 0, 1151, 0);  // bad -> 0
    add(1118, 1, 1, 0, 0, 1118, 0);  // good 1
    add(1150, 1, 1, 0, 0, 1150, 0);  // good 2
    add(1134, 1, 1, 0, 0, 1134, 0);  // 3
    add(1134, 1, 1, 0, 0, 1134, 0);  // 4
    add(1120, 1, 1, 0, 0, 1120, 0);  // 5
    add(1148, 1, 1, 0, 0, 1148, 0);  // 6
    add(1134, 1, 1, 0, 0, 1134, 0);  // 7
    add(1117, 1, 1, 0, 0, 1117, 0);  // bad -> 0
    add(1134, 1, 1, 0, 0, 1134, 0);  // 1
    add(1118, 1, 1, 0, 0, 1118, 0);  // 2
    add(1150, 1, 1, 0, 0, 1150, 0);  // 3
    add(1134, 1, 1, 0, 0, 1134, 0);  // 4
    add(1134, 1, 1, 0, 0, 1134, 0);  // 5
    add(1134, 1, 1, 0, 0, 1134, 0);  // 6
    add(1134, 1, 1, 0, 0, 1134, 0);  // 7
    add(1134, 2, 0, 1, 1, 1134, 0);  // 8 -> LOCKED
    add(1200, 3, 1, 1, 1, 1200, 0);  // bad -> HOLDOVER
    add(1134, 2, 0, 1, 1, 1134, 0);  // good -> LOCKED
    add(1200, 3, 1, 1, 1, 1200, 0);  // HOLDOVER, bad_cnt 1
    add(1100, 4, 1, 0, 0, 1100, 1);  // bad_cnt 2 -> FAULT

    // Reset state
    gap(3);
    rst = 1'b0;
    check_outs("reset", 0, 1, 0, 0, 0);
    check("reset_period", 32'(period), 32'd0);

    enable = 1'b1;
    tick();
    check_outs("enter_acq", 1, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      gap(vecs[i].len - 1);
      edge_tick();
      check_outs($sformatf("v%0d", i), vecs[i].st, vecs[i].mute, vecs[i].ll, vecs[i].src,
                 vecs[i].err);
      if (vecs[i].per >= 0)
        check($sformatf("v%0d_period", i), 32'(period), 32'(vecs[i].per));
    end
    tick();
    check_outs("fault_to_acq", 1, 1, 0, 0, 1);

    // Word clock stops while locked: holdover after one timeout, fault after two
    relock(1'b0, 1);
    gap(2267);
    check("to_before_1st", 32'(state), 32'd2);
    tick();
    check_outs("to_holdover", 3, 1, 1, 1, 1);
    gap(2267);
    check("to_before_2nd", 32'(state), 32'd3);
    tick();
    check_outs("to_fault", 4, 1, 0, 0, 2);
    tick();
    check_outs("to_acquire", 1, 1, 0, 0, 2);

    // pll drops on the same cycle as a good edge: fault wins
    relock(1'b1, 2);
    gap(1133);
    pll_locked = 1'b0;
    edge_tick();
    pll_locked = 1'b1;
    check_outs("pll_drop", 4, 1, 0, 0, 3);
    tick();
    check("pll_drop_acq", 32'(state), 32'd1);

    // enable low mid-LOCKED: idle outputs, fault count kept
    relock(1'b0, 3);
    enable = 1'b0;
    tick();
    check_outs("disable", 0, 1, 0, 0, 3);
    check("disable_period", 32'(period), 32'd0);
    enable = 1'b1;
    tick();
    check("reenable", 32'(state), 32'd1);

    // rst mid-LOCKED: everything cleared
    relock(1'b0, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_outs("mid_rst", 0, 1, 0, 0, 0);
    check("mid_rst_period", 32'(period), 32'd0);
    tick();
    check("after_rst_acq", 32'(state), 32'd1);

    // err_clr on the fault-entry cycle beats the increment
    relock(1'b0, 0);
    gap(1133);
    pll_locked = 1'b0;
    err_clr = 1'b1;
    edge_tick();
    pll_locked = 1'b1;
    err_clr = 1'b0;
    check_outs("clr_vs_inc", 4, 1, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lightpipe_link_ctrl.md
Name: lightpipe_link_ctrl

Overview:
Link supervisor for the ADAT lightpipe receive path. It watches the word clock recovered by lightpipe_recv and the dpll lock flag, and measures the frame period in mclk cycles. It sequences acquisition, lock, holdover and fault. It drives the mute and clock-source select that recv_sync and downstream audio use, and counts link faults.

Parameters:
NOM_PERIOD, 1134, nominal mclk cycles per frame (50 MHz / 44.1 kHz)
TOL, 16, allowed absolute deviation of a measured period from NOM_PERIOD
LOCK_FRAMES, 8, consecutive good frames required to declare lock
LOSS_FRAMES, 2, consecutive bad frames tolerated in HOLDOVER before FAULT
CNT_W, 12, width of period counter and period output

Ports:
mclk  in  1  system clock
rst  in  1  synchronous reset, active-high
enable  in  1  supervisor enable; 0 forces IDLE
rx_wordclock  in  1  recovered word clock from lightpipe_recv (mclk-synchronous level)
pll_locked  in  1  dpll lock indication
err_clr  in  1  clears err_count
mute  out  1  1 = downstream audio muted
link_locked  out  1  1 = link usable (LOCKED or HOLDOVER)
src_sel  out  1  0 = internal word clock, 1 = recovered word clock
state  out  3  current FSM state code
period  out  CNT_W  last measured frame period
err_count  out  8  number of FAULT entries, saturating

Behaviour:
- Reset/IDLE outputs: mute=1, link_locked=0, src_sel=0, state=IDLE, period=0, err_count=0 (err_count cleared only by rst or err_clr, not by IDLE).
- Edge detect: one register stage on rx_wordclock. A rising edge is registered low and input high, detected in cycle n. All outputs are registered and reflect that edge in cycle n+1.
- Period counter: cleared to 0 on an edge cycle, +1 every other cycle, saturates at 2^CNT_W-1.
- On an edge, period <= cnt+1, so edges 1134 cycles apart give period=1134.
- Good frame: NOM_PERIOD-TOL <= period <= NOM_PERIOD+TOL, inclusive. Otherwise the frame is bad.
- Timeout: cnt reaching 2*NOM_PERIOD-1 with no edge counts as a bad-frame event, and cnt restarts at 0. Timeouts repeat every 2*NOM_PERIOD cycles.
- Primed flag: cleared on entry to ACQUIRE. The first edge after entry only starts measurement, is neither good nor bad, and sets primed. Timeouts count even when unprimed.
- State codes: IDLE=0, ACQUIRE=1, LOCKED=2, HOLDOVER=3, FAULT=4.
- IDLE: enable=1 -> ACQUIRE.
- ACQUIRE: mute=1, link_locked=0, src_sel=0.
  - Good frame: good_cnt+1. Bad frame or timeout: good_cnt=0.
  - good_cnt reaching LOCK_FRAMES with pll_locked=1 -> LOCKED.
  - If pll_locked=0, good_cnt holds at LOCK_FRAMES; lock is taken on the first cycle pll_locked=1.
- LOCKED: mute=0, link_locked=1, src_sel=1.
  - Bad frame or timeout -> HOLDOVER with bad_cnt=1.
- HOLDOVER: mute=1, link_locked=1, src_sel=1.
  - Good frame -> LOCKED, bad_cnt=0.
  - Bad frame or timeout: bad_cnt+1; reaching LOSS_FRAMES -> FAULT.
- pll_locked=0 in LOCKED or HOLDOVER -> FAULT next cycle. This has priority over frame events in the same cycle.
- FAULT: mute=1, link_locked=0, src_sel=0. err_count+1 on entry, saturating at 255. Stays one cycle, then -> ACQUIRE with good_cnt=0, bad_cnt=0, primed=0.
- err_clr=1 clears err_count; clear wins over a simultaneous increment.
- enable=0 in any state -> IDLE next cycle (outputs as reset, err_count kept). rst has priority over everything, including mid-frame.

Decomposition:
- lightpipe_pkg holds:
  - state encoding: enum with the five codes above;
  - defaults: NOM_PERIOD_44K1=1134 and NOM_PERIOD_48K=1042;
  - width constants.
- Sub-module wc_period_meter holds the edge detect, period counter, timeout and good/bad classification. Its outputs are edge, good, bad, timeout and period.
- lightpipe_link_ctrl holds the FSM, frame counters and err_count.

Test Plan:
- Wordclock every 1134 cycles, pll_locked=1, enable=1 -> link_locked=1, mute=0, src_sel=1, state=2, one cycle after the 9th edge (1 priming + 8 good); period=1134.
- Classification boundaries in ACQUIRE:
  - periods 1118 and 1150 -> good, good_cnt increments;
  - periods 1117 and 1151 -> good_cnt resets and lock is delayed by 8 further good frames.
- LOCKED, then one period of 1200 -> state=3, mute=1, link_locked=1; next 1134 period -> state=2, mute=0.
- LOCKED, then wordclock stopped:
  - at 2268 cycles -> HOLDOVER;
  - at 4536 cycles -> FAULT for one cycle, err_count=1, then ACQUIRE, mute=1, src_sel=0.
- LOCKED, pll_locked dropped in the same cycle as a good edge -> FAULT, err_count increments. With err_clr asserted that cycle, err_count=0 instead.
- rst=1 or enable=0 mid-LOCKED -> next cycle state=0, mute=1, link_locked=0, src_sel=0. With enable=0, err_count is retained; with rst, all outputs including err_count are 0.
